// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: start bit, data MSB-first, optional parity bit, stop bit.
// Each line bit is held for BIT_CYCLES clocks; the line idles low.
module seq_frame_tx #(
    parameter int DATA_W     = 8,
    parameter int BIT_CYCLES = 1,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              tx_out,
    output logic              tx_busy,
    output logic              tx_done
);

    localparam int CYC_W = $clog2(BIT_CYCLES) + 1;
    localparam int BIT_W = $clog2(DATA_W) + 1;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYCLES - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic             ODD_BIT  = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                parity_q, parity_d;
    logic [CYC_W-1:0]    cyc_q, cyc_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic                tx_out_q, tx_out_d;
    logic                tx_busy_q, tx_busy_d;
    logic                tx_done_q, tx_done_d;
    logic                cyc_last;

    assign cyc_last = (cyc_q == CYC_LAST);
    assign in_ready = (state_q == IDLE);

    always_comb begin
        // NOTE: every variable gets a default before the case so no latch is inferred.
        state_d  = state_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        cyc_d    = cyc_q;
        bit_d    = bit_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d  = START;
                    shift_d  = in_data;
                    parity_d = (^in_data) ^ ODD_BIT;
                    cyc_d    = '0;
                    bit_d    = '0;
                end
            end
            START: begin
                if (cyc_last) begin
                    state_d = DATA;
                    cyc_d   = '0;
                    bit_d   = '0;
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            DATA: begin
                if (cyc_last) begin
                    cyc_d = '0;
                    if (bit_q == BIT_LAST) begin
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        shift_d = shift_q << 1;
                    end
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            PARITY: begin
                if (cyc_last) begin
                    state_d = STOP;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            STOP: begin
                if (cyc_last) begin
                    state_d = IDLE;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so the line level lands
    // in the same cycle the state is entered.
    always_comb begin
        tx_out_d = 1'b0;
        unique case (state_d)
            START:   tx_out_d = 1'b1;
            DATA:    tx_out_d = shift_d[DATA_W-1];
            PARITY:  tx_out_d = parity_d;
            default: tx_out_d = 1'b0;
        endcase
        tx_busy_d = (state_d != IDLE);
        tx_done_d = (state_q == STOP) && (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            cyc_q     <= '0;
            bit_q     <= '0;
            tx_out_q  <= 1'b0;
            tx_busy_q <= 1'b0;
            tx_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            cyc_q     <= cyc_d;
            bit_q     <= bit_d;
            tx_out_q  <= tx_out_d;
            tx_busy_q <= tx_busy_d;
            tx_done_q <= tx_done_d;
        end
    end

    assign tx_out  = tx_out_q;
    assign tx_busy = tx_busy_q;
    assign tx_done = tx_done_q;

endmodule

// File: tb/tb_seq_frame_tx.sv
// Bench for seq_frame_tx: four parameterisations driven side by side, each frame
// checked cycle by cycle against a bit list built from the framing rules.
module tb_seq_frame_tx;

    logic       clk;
    logic       rst_n;
    logic       valid_w  [4];
    logic [7:0] data_w   [4];
    logic       ready_w  [4];
    logic       tx_out_w [4];
    logic       busy_w   [4];
    logic       done_w   [4];

    // Unit configurations: bit cycles, parity enable, odd parity.
    int cfg_bc   [4] = '{1, 1, 1, 4};
    int cfg_pen  [4] = '{1, 1, 0, 1};
    int cfg_podd [4] = '{0, 1, 0, 0};

    int n_cmp = 0;
    int n_err = 0;

    seq_frame_tx #(.DATA_W(8), .BIT_CYCLES(1), .PARITY_EN(1), .PARITY_ODD(0)) u_even (
        .clk(clk), .rst_n(rst_n), .in_valid(valid_w[0]), .in_data(data_w[0]),
        .in_ready(ready_w[0]), .tx_out(tx_out_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]));
    seq_frame_tx #(.DATA_W(8), .BIT_CYCLES(1), .PARITY_EN(1), .PARITY_ODD(1)) u_odd (
        .clk(clk), .rst_n(rst_n), .in_valid(valid_w[1]), .in_data(data_w[1]),
        .in_ready(ready_w[1]), .tx_out(tx_out_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]));
    seq_frame_tx #(.DATA_W(8), .BIT_CYCLES(1), .PARITY_EN(0), .PARITY_ODD(0)) u_nopar (
        .clk(clk), .rst_n(rst_n), .in_valid(valid_w[2]), .in_data(data_w[2]),
        .in_ready(ready_w[2]), .tx_out(tx_out_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]));
    seq_frame_tx #(.DATA_W(8), .BIT_CYCLES(4), .PARITY_EN(1), .PARITY_ODD(0)) u_slow (
        .clk(clk), .rst_n(rst_n), .in_valid(valid_w[3]), .in_data(data_w[3]),
        .in_ready(ready_w[3]), .tx_out(tx_out_w[3]), .tx_busy(busy_w[3]), .tx_done(done_w[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Call just after the acceptance edge; checks cycles k+1 .. k+L+1.
    task automatic expect_frame(input int u, input logic [7:0] w);
        bit q[$];
        int bc;
        int len;
        bc = cfg_bc[u];
        q.push_back(1'b1);
        for (int i = 7; i >= 0; i--) q.push_back(w[i]);
        if (cfg_pen[u] != 0) q.push_back((^w) ^ (cfg_podd[u] != 0));
        q.push_back(1'b0);
        len = q.size() * bc;
        for (int j = 0; j < len; j++) begin
            @(negedge clk);
            check($sformatf("u%0d_line_c%0d", u, j + 1), 32'(tx_out_w[u]), 32'(q[j / bc]));
            check($sformatf("u%0d_busy_c%0d", u, j + 1), 32'(busy_w[u]), 32'd1);
            check($sformatf("u%0d_done_c%0d", u, j + 1), 32'(done_w[u]), 32'd0);
            check($sformatf("u%0d_ready_c%0d", u, j + 1), 32'(ready_w[u]), 32'd0);
        end
        @(negedge clk);
        check($sformatf("u%0d_done_end", u), 32'(done_w[u]), 32'd1);
        check($sformatf("u%0d_busy_end", u), 32'(busy_w[u]), 32'd0);
        check($sformatf("u%0d_line_end", u), 32'(tx_out_w[u]), 32'd0);
        check($sformatf("u%0d_ready_end", u), 32'(ready_w[u]), 32'd1);
    endtask

    // Offer a word at a falling edge and wait (bounded) for acceptance.
    task automatic accept(input int u, input logic [7:0] w);
        int waited;
        @(negedge clk);
        valid_w[u] = 1'b1;
        data_w[u]  = w;
        waited = 0;
        while (ready_w[u] !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 100) check($sformatf("u%0d_ready_timeout", u), 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int u, input logic [7:0] w);
        accept(u, w);
        valid_w[u] = 1'b0;
        data_w[u]  = 8'($urandom);
        expect_frame(u, w);
        @(negedge clk);
        check($sformatf("u%0d_done_once", u), 32'(done_w[u]), 32'd0);
        check($sformatf("u%0d_idle_line", u), 32'(tx_out_w[u]), 32'd0);
    endtask

    initial begin
        for (int u = 0; u < 4; u++) begin
            valid_w[u] = 1'b0;
            data_w[u]  = 8'h00;
        end

        // Reset held two edges with a word offered: nothing may start.
        rst_n = 1'b0;
        for (int u = 0; u < 4; u++) begin
            valid_w[u] = 1'b1;
            data_w[u]  = 8'hA5;
        end
        repeat (2) begin
            @(negedge clk);
            for (int u = 0; u < 4; u++) begin
                check($sformatf("rst_u%0d_line", u), 32'(tx_out_w[u]), 32'd0);
                check($sformatf("rst_u%0d_busy", u), 32'(busy_w[u]), 32'd0);
                check($sformatf("rst_u%0d_done", u), 32'(done_w[u]), 32'd0);
            end
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        for (int u = 0; u < 4; u++) begin
            check($sformatf("rel_u%0d_ready", u), 32'(ready_w[u]), 32'd1);
            check($sformatf("rel_u%0d_busy", u), 32'(busy_w[u]), 32'd0);
            check($sformatf("rel_u%0d_line", u), 32'(tx_out_w[u]), 32'd0);
            valid_w[u] = 1'b0;
        end

        // Directed frames for each configuration.
        send(0, 8'hA5);
        send(1, 8'h07);
        send(2, 8'h07);
        send(3, 8'h80);

        // Back-to-back: valid held high, data changed while busy must be ignored.
        accept(0, 8'h3C);
        data_w[0] = 8'hC3;
        expect_frame(0, 8'h3C);
        @(posedge clk);
        #1;
        valid_w[0] = 1'b0;
        expect_frame(0, 8'hC3);
        @(negedge clk);
        check("b2b_done_once", 32'(done_w[0]), 32'd0);

        // Reset during data bit 3 of 8'hFF aborts the frame.
        accept(0, 8'hFF);
        valid_w[0] = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_pre_line", 32'(tx_out_w[0]), 32'd1);
        check("abort_pre_busy", 32'(busy_w[0]), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check($sformatf("abort_line_c%0d", c), 32'(tx_out_w[0]), 32'd0);
            check($sformatf("abort_done_c%0d", c), 32'(done_w[0]), 32'd0);
            check($sformatf("abort_busy_c%0d", c), 32'(busy_w[0]), 32'd0);
        end
        send(0, 8'h5A);

        // Random words with random idle gaps on every configuration.
        for (int u = 0; u < 4; u++) begin
            for (int n = 0; n < 20; n++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                send(u, 8'($urandom));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
